fetch_skid_buffer: RTL and testbench
====================================

# fetch_skid_buffer

Two-entry instruction skid buffer between the instruction fetch unit and the decode stage. It captures each fetched instruction word with its PC+4 value and presents them in order to decode with a valid/ready handshake. Decode can stall without combinational ready paths back into fetch, and a branch or jump redirect can discard everything in flight.

## Interface
Parameters:
- DEPTH, 2: number of entries; fixed at 2, pointers are 1 bit.
- RESET_PC_NEXT, 32'h00003004: value driven on out_pc_next while the buffer is empty.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately).
- in_valid  input  1  fetch presents a word this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc_next  input  32  PC+4 of the fetched word.
- in_ready  output  1  buffer accepts a word this cycle.
- out_valid  output  1  decode-side word valid.
- out_instr  output  32  head instruction; 32'h00000000 (nop) when out_valid==0.
- out_pc_next  output  32  head PC+4; RESET_PC_NEXT when out_valid==0.
- out_ready  input  1  decode consumes head this cycle.
- flush  input  1  synchronous discard of all entries (redirect).
- count  output  2  current occupancy, 0..2.

## Operation
- Storage: 2 entries × 64 bits {instr, pc_next}, write pointer wr_ptr, read pointer rd_ptr (1 bit each), occupancy cnt[1:0].
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- in_ready = (cnt != 2). It depends only on registered state, never on out_ready or in_valid.
- out_valid = (cnt != 0) in the base build.
- Push writes mem[wr_ptr] and toggles wr_ptr. Pop toggles rd_ptr.
- cnt update: push&~pop → +1; pop&~push → −1; both or neither → unchanged.
- Pointers wrap naturally (1-bit toggle). Entries are delivered strictly in push order.
- When full (cnt==2), in_ready=0. A pop that cycle lowers cnt to 1, so in_ready=1 next cycle. There is no same-cycle refill.
- When empty, a simultaneous in_valid and out_ready produce a push only (base build), and the word appears next cycle.
- flush=1: next edge sets cnt=0 and rd_ptr=wr_ptr=0. Any same-cycle push is dropped, and any same-cycle handshake is not counted as a pop (decode must also ignore it). flush has priority over all other events.
- Asynchronous reset (reset==0):
  - cnt=0, rd_ptr=wr_ptr=0, all storage 0.
  - Outputs: out_valid=0, in_ready=1, count=0, out_instr=0, out_pc_next=RESET_PC_NEXT.
- Reset deassertion mid-stream: the first accepted word is the first in_valid seen at a rising edge with reset==1.

## Timing
- Base latency: a word pushed at edge N is visible on out_* after edge N and can be popped at edge N+1.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- in_ready, out_valid and count are glitch-free register-derived signals. out_instr and out_pc_next are a mux of storage by rd_ptr.
- The only combinational input→output path is the optional bypass (see Configuration).

## Configuration
- Macro: FETCH_SKID_BYPASS_EN.
- Defined:
  - When cnt==0 and in_valid=1 and flush=0, then out_valid=1 and out_instr/out_pc_next = in_instr/in_pc_next combinationally.
  - If out_ready=1 that cycle, the word is consumed with no write and cnt stays 0 (zero latency).
  - If out_ready=0, the word is written normally and cnt becomes 1.
  - For cnt≠0, behaviour is identical to the base build.
- Undefined: no bypass. Empty-to-output latency is exactly 1 cycle, and no in_* → out_* combinational path exists.

## Test plan
- Reset: hold reset=0 with in_valid=1 and in_instr=32'h3c010001. Required: out_valid=0, out_instr=0, out_pc_next=32'h00003004, in_ready=1, count=0 throughout. Release reset, push once, then pop next cycle → out_instr=32'h3c010001.
- Streaming: push 8 words 32'h1000_0000+i with pc_next 32'h3004+4i, out_ready=1 continuously. Required: all 8 emerged in order, one per cycle, count≤1 (base) or 0 (bypass).
- Backpressure: out_ready=0, push 3 words. Required: count=2 and in_ready=0 after the second push, third word not accepted. Raise out_ready for 1 cycle → count=1 and in_ready=1 next cycle. Third word then accepted, and the order is preserved.
- Wrap: alternate push/pop for 5 cycles, then fill to 2 and drain. Required: in-order data across pointer wrap, no duplicates or drops.
- Flush: with count=2, assert flush together with in_valid=1 and out_ready=1. Required: next cycle count=0, out_valid=0 and out_instr=0. The flush-cycle input is not delivered later.
- Async reset mid-operation: with count=2, pulse reset=0 between edges. Required: outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
//
// Two-entry skid buffer between instruction fetch and decode. Each accepted
// word is stored with its PC+4 value and is presented to decode in arrival
// order through a valid/ready handshake. in_ready is derived from registered
// occupancy only, so decode stalls never form a combinational path back into
// fetch. A flush (branch/jump redirect) discards every buffered entry.
//
// Optional feature: define FETCH_SKID_BYPASS_EN to let a word arriving at an
// empty buffer appear on out_* in the same cycle. It is consumed directly if
// decode is ready, and is stored otherwise.
//
// Parameters
//   DEPTH          number of entries (fixed at 2; pointers are 1 bit)
//   RESET_PC_NEXT  value shown on out_pc_next while nothing is valid
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     fetch presents a word
//   in_instr     fetched instruction word
//   in_pc_next   PC+4 of the fetched word
//   in_ready     buffer can accept a word this cycle
//   out_valid    head word valid toward decode
//   out_instr    head instruction (0 when out_valid is low)
//   out_pc_next  head PC+4 (RESET_PC_NEXT when out_valid is low)
//   out_ready    decode consumes the head this cycle
//   flush        discard all entries at the next edge
//   count        current occupancy, 0..2
// ---------------------------------------------------------------------------
module fetch_skid_buffer #(
    parameter int unsigned DEPTH         = 2,
    parameter logic [31:0] RESET_PC_NEXT = 32'h0000_3004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc_next,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_next,
    input  logic        out_ready,
    input  logic        flush,
    output logic [1:0]  count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [63:0] mem_q [2];
    logic [63:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        stored_valid;
    logic [63:0] head;
    logic        push;
    logic        pop;

    // Handshake and output selection
    always_comb begin
        stored_valid = (cnt_q != 2'd0);
        head         = mem_q[rd_ptr_q];
        in_ready     = (cnt_q != FULL);
        count        = cnt_q;
        out_valid    = 1'b0;
        out_instr    = '0;
        out_pc_next  = RESET_PC_NEXT;
        push         = 1'b0;
        pop          = 1'b0;

`ifdef FETCH_SKID_BYPASS_EN
        if (stored_valid) begin
            out_valid   = 1'b1;
            out_instr   = head[63:32];
            out_pc_next = head[31:0];
            pop         = out_ready & ~flush;
            push        = in_valid & in_ready & ~flush;
        end else if (in_valid && !flush) begin
            // Empty buffer: forward fetch straight to decode; only store the
            // word if decode does not take it this cycle.
            out_valid   = 1'b1;
            out_instr   = in_instr;
            out_pc_next = in_pc_next;
            push        = ~out_ready;
        end
`else
        if (stored_valid) begin
            out_valid   = 1'b1;
            out_instr   = head[63:32];
            out_pc_next = head[31:0];
        end
        push = in_valid & in_ready & ~flush;
        pop  = out_valid & out_ready & ~flush;
`endif
    end

    // Next-state computation; flush overrides every other event
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_instr, in_pc_next};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_skid_buffer.sv
module tb_fetch_skid_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc_next;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;
    logic        out_ready;
    logic        flush;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_skid_buffer #(
        .DEPTH         (2),
        .RESET_PC_NEXT (32'h0000_3004)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc_next  (in_pc_next),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc_next (out_pc_next),
        .out_ready   (out_ready),
        .flush       (flush),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"},   32'(out_valid),   32'd0);
        check({tag, " out_instr"},   out_instr,        32'h0);
        check({tag, " out_pc_next"}, out_pc_next,      32'h0000_3004);
        check({tag, " in_ready"},    32'(in_ready),    32'd1);
        check({tag, " count"},       32'(count),       32'd0);
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pcn);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_pc_next = pcn;
    endtask

    initial begin
        // ---------------- reset held with fetch active ----------------
        reset      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        present(32'h3c01_0001, 32'h0000_3008);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_idle("reset_hold");
            tick();
        end
        check_idle("reset_hold");
        reset = 1'b1;
        tick();
        check("first_push count", 32'(count), 32'd1);
        check("first_push instr", out_instr, 32'h3c01_0001);
        check("first_push pcn",   out_pc_next, 32'h0000_3008);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_idle("first_pop");

        // ---------------- streaming, out_ready held high ----------------
        for (int i = 0; i < 8; i++) begin
            present(32'h1000_0000 + 32'(i), 32'h0000_3004 + 32'(4 * i));
            tick();
            check("stream instr", out_instr, 32'h1000_0000 + 32'(i));
            check("stream pcn",   out_pc_next, 32'h0000_3004 + 32'(4 * i));
            check("stream count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream drained", 32'(count), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        present(32'h2000_0000, 32'h0000_4000);
        tick();
        check("bp count1",    32'(count), 32'd1);
        check("bp in_ready1", 32'(in_ready), 32'd1);
        present(32'h2000_0001, 32'h0000_4004);
        tick();
        check("bp count2",    32'(count), 32'd2);
        check("bp in_ready0", 32'(in_ready), 32'd0);
        check("bp head A",    out_instr, 32'h2000_0000);
        present(32'h2000_0002, 32'h0000_4008);
        tick();
        check("bp C refused", 32'(count), 32'd2);
        check("bp head A2",   out_instr, 32'h2000_0000);
        out_ready = 1'b1;
        tick();
        check("bp pop count", 32'(count), 32'd1);
        check("bp pop ready", 32'(in_ready), 32'd1);
        check("bp head B",    out_instr, 32'h2000_0001);
        out_ready = 1'b0;
        tick();
        check("bp C taken",   32'(count), 32'd2);
        check("bp head B2",   out_instr, 32'h2000_0001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp head C",    out_instr, 32'h2000_0002);
        check("bp pcn C",     out_pc_next, 32'h0000_4008);
        tick();
        check("bp empty",     32'(count), 32'd0);

        // ---------------- pointer wrap ----------------
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            present(32'h3000_0000 + 32'(k), 32'h0000_5000 + 32'(4 * k));
            tick();
            check("wrap instr", out_instr, 32'h3000_0000 + 32'(k));
            check("wrap count", 32'(count), 32'd1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            check("wrap empty", 32'(count), 32'd0);
        end
        out_ready = 1'b0;
        present(32'h4000_0000, 32'h0000_6000);
        tick();
        present(32'h4000_0001, 32'h0000_6004);
        tick();
        in_valid = 1'b0;
        check("wrap full",   32'(count), 32'd2);
        check("wrap head0",  out_instr, 32'h4000_0000);
        out_ready = 1'b1;
        tick();
        check("wrap head1",  out_instr, 32'h4000_0001);
        check("wrap pcn1",   out_pc_next, 32'h0000_6004);
        check("wrap cnt1",   32'(count), 32'd1);
        tick();
        check("wrap drained", 32'(count), 32'd0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        present(32'h5000_0000, 32'h0000_7000);
        tick();
        present(32'h5000_0001, 32'h0000_7004);
        tick();
        check("flush pre count", 32'(count), 32'd2);
        present(32'h5000_0002, 32'h0000_7008);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush");
        tick();
        check("flush no ghost", 32'(count), 32'd0);
        out_ready = 1'b0;
        present(32'h6000_0000, 32'h0000_8000);
        tick();
        in_valid = 1'b0;
        check("post flush head", out_instr, 32'h6000_0000);
        check("post flush cnt",  32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        check("post flush empty", 32'(count), 32'd0);

        // ---------------- async reset mid-operation ----------------
        out_ready = 1'b0;
        present(32'h7000_0000, 32'h0000_9000);
        tick();
        present(32'h7000_0001, 32'h0000_9004);
        tick();
        in_valid = 1'b0;
        check("areset pre count", 32'(count), 32'd2);
        check("areset pre head",  out_instr, 32'h7000_0000);
        #1;
        reset = 1'b0;
        #1;
        check_idle("areset");
        reset = 1'b1;
        tick();
        check_idle("areset after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
